// File: rtl/mvm_out_serializer.sv
// Captures one parallel MVM result, rescales/saturates each sum and streams it out one element per beat.
// Optional build macro MVM_SER_RELU_EN applies ReLU after the shift and before saturation.
module mvm_out_serializer #(
    parameter int VECTOR_SIZE    = 3,
    parameter int MATRIX_COLUMNS = 3,
    parameter int WIDTH_ELEMENT  = 5,
    parameter int FRAC_BITS      = 2,
    localparam int IW            = 2 * WIDTH_ELEMENT + VECTOR_SIZE,
    localparam int IDXW          = (MATRIX_COLUMNS > 1) ? $clog2(MATRIX_COLUMNS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IW*MATRIX_COLUMNS-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_ELEMENT-1:0]     out_data,
    output logic [IDXW-1:0]              out_index,
    output logic                         out_last,
    output logic                         sat_flag
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(MATRIX_COLUMNS - 1);
    localparam logic signed [IW-1:0] MAX_V    = IW'((1 << (WIDTH_ELEMENT - 1)) - 1);
    localparam logic signed [IW-1:0] MIN_V    = IW'(-(1 << (WIDTH_ELEMENT - 1)));

    state_t                 state;
    logic [IDXW-1:0]        idx;
    logic signed [IW-1:0]   buffer [MATRIX_COLUMNS];
    logic signed [IW-1:0]   shifted;
    logic [WIDTH_ELEMENT-1:0] elem;
    logic                   elem_sat;
    logic                   beat;

    // Element path depends only on registered buffer/idx, so it holds steady during stalls.
    always_comb begin
        shifted  = buffer[idx] >>> FRAC_BITS;
        elem     = shifted[WIDTH_ELEMENT-1:0];
        elem_sat = 1'b0;
`ifdef MVM_SER_RELU_EN
        if (shifted < 0) begin
            elem = '0;
        end else if (shifted > MAX_V) begin
            elem     = MAX_V[WIDTH_ELEMENT-1:0];
            elem_sat = 1'b1;
        end
`else
        if (shifted > MAX_V) begin
            elem     = MAX_V[WIDTH_ELEMENT-1:0];
            elem_sat = 1'b1;
        end else if (shifted < MIN_V) begin
            elem     = MIN_V[WIDTH_ELEMENT-1:0];
            elem_sat = 1'b1;
        end
`endif
    end

    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (idx == LAST_IDX);
    assign out_data  = elem;
    assign out_index = idx;
    assign beat      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (beat && out_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            sat_flag <= 1'b0;
            for (int k = 0; k < MATRIX_COLUMNS; k++) buffer[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < MATRIX_COLUMNS; k++) buffer[k] <= in_data[k*IW +: IW];
                        idx      <= '0;
                        sat_flag <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        // A capture on the last beat starts a new frame, so its clear wins.
                        if (out_last && in_valid) begin
                            for (int k = 0; k < MATRIX_COLUMNS; k++) buffer[k] <= in_data[k*IW +: IW];
                            idx      <= '0;
                            sat_flag <= 1'b0;
                        end else begin
                            sat_flag <= sat_flag | elem_sat;
                            if (out_last) begin
                                idx   <= '0;
                                state <= IDLE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
